// File: rtl/plate_pkg.sv
// Shared definitions for the plate ID history block.
// Holds the default plate geometry, the blank digit code, the debounce
// FSM state type and a reading-validity helper for the default geometry.
package plate_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 5;
  localparam int unsigned ENTRY_W    = NUM_DIGITS * DIGIT_W;

  localparam logic [DIGIT_W-1:0] BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } plate_state_e;

  // True when any digit of a default-geometry reading is the blank code.
  function automatic logic is_blank(input logic [ENTRY_W-1:0] entry);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (entry[i*DIGIT_W +: DIGIT_W] == BLANK) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/plate_id_history_ram.sv
// Circular plate history storage.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   clear         synchronous clear back to reset values (beats push)
//   push          commit attempt with push_data
//   written_c     combinational: this push is actually stored
//   rd_idx        logical read index, 0 = oldest entry
//   rd_data       registered read data, all-blank past count
//   hist_flat     physical slots, slot i at [i*ENTRY_W +: ENTRY_W]
//   wr_ptr        next physical slot to write
//   count, full   occupancy
//   overflow      sticky: a push arrived while full
module plate_hist_ram #(
  parameter int unsigned     ENTRY_W     = 20,
  parameter int unsigned     HIST_DEPTH  = 20,
  parameter bit              OVERWRITE   = 1'b1,
  parameter logic [ENTRY_W-1:0] BLANK_ENTRY = '1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clear,
  input  logic                               push,
  input  logic [ENTRY_W-1:0]                 push_data,
  output logic                               written_c,
  input  logic [$clog2(HIST_DEPTH)-1:0]      rd_idx,
  output logic [ENTRY_W-1:0]                 rd_data,
  output logic [HIST_DEPTH*ENTRY_W-1:0]      hist_flat,
  output logic [$clog2(HIST_DEPTH)-1:0]      wr_ptr,
  output logic [$clog2(HIST_DEPTH+1)-1:0]    count,
  output logic                               full,
  output logic                               overflow
);

  localparam int unsigned IW = $clog2(HIST_DEPTH);
  localparam int unsigned CW = $clog2(HIST_DEPTH + 1);
  localparam int unsigned SW = IW + 1;

  logic [ENTRY_W-1:0] slot_q [HIST_DEPTH];
  logic [IW-1:0]      wr_ptr_q;
  logic [IW-1:0]      oldest_q;
  logic [CW-1:0]      count_q;
  logic               full_q;
  logic               overflow_q;
  logic [ENTRY_W-1:0] rd_data_q;

  logic [SW-1:0]      rd_sum_c;
  logic [IW-1:0]      rd_phys_c;
  logic [ENTRY_W-1:0] rd_data_c;

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
    return (p == IW'(HIST_DEPTH - 1)) ? '0 : p + IW'(1);
  endfunction

  // When full, the oldest slot is the one about to be overwritten.
  assign written_c = push && (!full_q || OVERWRITE);

  // Logical-to-physical read mapping; sum is below 2*HIST_DEPTH when in range.
  always_comb begin
    rd_sum_c  = SW'(oldest_q) + SW'(rd_idx);
    rd_phys_c = (rd_sum_c >= SW'(HIST_DEPTH)) ? IW'(rd_sum_c - SW'(HIST_DEPTH))
                                              : IW'(rd_sum_c);
    rd_data_c = BLANK_ENTRY;
    if (CW'(rd_idx) < count_q) rd_data_c = slot_q[rd_phys_c];
  end

  // Storage, pointers, occupancy and registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(HIST_DEPTH); i++) slot_q[i] <= BLANK_ENTRY;
      wr_ptr_q   <= '0;
      oldest_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      rd_data_q  <= BLANK_ENTRY;
    end else if (clear) begin
      for (int i = 0; i < int'(HIST_DEPTH); i++) slot_q[i] <= BLANK_ENTRY;
      wr_ptr_q   <= '0;
      oldest_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      rd_data_q  <= BLANK_ENTRY;
    end else begin
      if (written_c) begin
        slot_q[wr_ptr_q] <= push_data;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
        if (full_q) begin
          oldest_q <= ptr_inc(oldest_q);
        end else begin
          count_q <= count_q + CW'(1);
          full_q  <= (count_q == CW'(HIST_DEPTH - 1));
        end
      end
      if (push && full_q) overflow_q <= 1'b1;
      rd_data_q <= rd_data_c;
    end
  end

  for (genvar gi = 0; gi < int'(HIST_DEPTH); gi++) begin : g_flat
    assign hist_flat[gi*ENTRY_W +: ENTRY_W] = slot_q[gi];
  end

  assign rd_data  = rd_data_q;
  assign wr_ptr   = wr_ptr_q;
  assign count    = count_q;
  assign full     = full_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/plate_id_history.sv
// Debounces per-frame plate readings and commits each stable, new plate
// into a circular history.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   frame_end     one-cycle strobe qualifying digit
//   digit         current reading, digit 0 in LSBs
//   clear         synchronous clear of all state and history
//   rd_idx        logical read index, 0 = oldest; rd_data one cycle later
//   hist_flat     physical history slots
//   wr_ptr, count, full, overflow   history bookkeeping
//   stable_id     most recently committed plate
//   new_id        one-cycle pulse on each stored commit
module plate_id_history #(
  parameter int unsigned            NUM_DIGITS    = plate_pkg::NUM_DIGITS,
  parameter int unsigned            DIGIT_W       = plate_pkg::DIGIT_W,
  parameter logic [DIGIT_W-1:0]     BLANK         = plate_pkg::BLANK,
  parameter int unsigned            STABLE_FRAMES = 3,
  parameter int unsigned            HIST_DEPTH    = 20,
  parameter bit                     OVERWRITE     = 1'b1
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        frame_end,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]               digit,
  input  logic                                        clear,
  input  logic [$clog2(HIST_DEPTH)-1:0]               rd_idx,
  output logic [NUM_DIGITS*DIGIT_W-1:0]               rd_data,
  output logic [HIST_DEPTH*NUM_DIGITS*DIGIT_W-1:0]    hist_flat,
  output logic [$clog2(HIST_DEPTH)-1:0]               wr_ptr,
  output logic [$clog2(HIST_DEPTH+1)-1:0]             count,
  output logic [NUM_DIGITS*DIGIT_W-1:0]               stable_id,
  output logic                                        new_id,
  output logic                                        full,
  output logic                                        overflow
);
  import plate_pkg::*;

  localparam int unsigned EW = NUM_DIGITS * DIGIT_W;
  localparam int unsigned SW = $clog2(STABLE_FRAMES + 1);
  localparam logic [EW-1:0] BLANK_ENTRY = {NUM_DIGITS{BLANK}};

  plate_state_e   state_q, state_n;
  logic [EW-1:0]  cand_q, cand_n;
  logic [SW-1:0]  streak_q, streak_n;
  logic [EW-1:0]  stable_id_q;
  logic           new_id_q;

  logic           reading_blank_c;
  logic           commit_req_c;
  logic           push_c;
  logic           written_c;

  // A reading is invalid if any digit carries the blank code.
  always_comb begin
    reading_blank_c = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (digit[i*DIGIT_W +: DIGIT_W] == BLANK) reading_blank_c = 1'b1;
    end
  end

  // Debounce next-state: candidate, streak and commit request.
  always_comb begin
    state_n      = state_q;
    cand_n       = cand_q;
    streak_n     = streak_q;
    commit_req_c = 1'b0;
    if (frame_end) begin
      if (reading_blank_c) begin
        state_n  = IDLE;
        streak_n = '0;
      end else if (state_q == LOCKED && digit == cand_q) begin
        state_n = LOCKED;
      end else begin
        if (state_q == TRACK && digit == cand_q) begin
          streak_n = streak_q + SW'(1);
        end else begin
          cand_n   = digit;
          streak_n = SW'(1);
        end
        if (streak_n == SW'(STABLE_FRAMES)) begin
          state_n      = LOCKED;
          commit_req_c = 1'b1;
        end else begin
          state_n = TRACK;
        end
      end
    end
  end

  // Skip a commit that would just repeat the last stored plate.
  assign push_c = commit_req_c && !((count != '0) && (cand_n == stable_id_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cand_q      <= BLANK_ENTRY;
      streak_q    <= '0;
      stable_id_q <= BLANK_ENTRY;
      new_id_q    <= 1'b0;
    end else if (clear) begin
      state_q     <= IDLE;
      cand_q      <= BLANK_ENTRY;
      streak_q    <= '0;
      stable_id_q <= BLANK_ENTRY;
      new_id_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      cand_q   <= cand_n;
      streak_q <= streak_n;
      new_id_q <= written_c;
      if (written_c) stable_id_q <= cand_n;
    end
  end

  plate_hist_ram #(
    .ENTRY_W     (EW),
    .HIST_DEPTH  (HIST_DEPTH),
    .OVERWRITE   (OVERWRITE),
    .BLANK_ENTRY (BLANK_ENTRY)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .push      (push_c),
    .push_data (cand_n),
    .written_c (written_c),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data),
    .hist_flat (hist_flat),
    .wr_ptr    (wr_ptr),
    .count     (count),
    .full      (full),
    .overflow  (overflow)
  );

  assign stable_id = stable_id_q;
  assign new_id    = new_id_q;

endmodule

// File: tb/tb_plate_id_history.sv
// Self-checking bench: one overwrite and one drop-new instance share stimulus
// and are compared against a run-length based reference model.
module tb_plate_id_history;

  localparam int D  = 20;
  localparam int SF = 3;
  localparam int ND = 5;
  localparam int EW = 20;
  localparam logic [EW-1:0] BL = 20'hFFFFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_end = 1'b0;
  logic          clear = 1'b0;
  logic [EW-1:0] digit = '0;
  logic [4:0]    rd_idx = '0;

  logic [EW-1:0]   rd_data   [2];
  logic [D*EW-1:0] hist_flat [2];
  logic [4:0]      wr_ptr    [2];
  logic [4:0]      count     [2];
  logic [EW-1:0]   stable_id [2];
  logic            new_id    [2];
  logic            full      [2];
  logic            overflow  [2];

  always #5 clk = ~clk;

  plate_id_history #(.STABLE_FRAMES(SF), .HIST_DEPTH(D), .OVERWRITE(1'b1)) dut_ow (
    .clk(clk), .rst_n(rst_n), .frame_end(frame_end), .digit(digit), .clear(clear),
    .rd_idx(rd_idx), .rd_data(rd_data[0]), .hist_flat(hist_flat[0]), .wr_ptr(wr_ptr[0]),
    .count(count[0]), .stable_id(stable_id[0]), .new_id(new_id[0]), .full(full[0]),
    .overflow(overflow[0]));

  plate_id_history #(.STABLE_FRAMES(SF), .HIST_DEPTH(D), .OVERWRITE(1'b0)) dut_drop (
    .clk(clk), .rst_n(rst_n), .frame_end(frame_end), .digit(digit), .clear(clear),
    .rd_idx(rd_idx), .rd_data(rd_data[1]), .hist_flat(hist_flat[1]), .wr_ptr(wr_ptr[1]),
    .count(count[1]), .stable_id(stable_id[1]), .new_id(new_id[1]), .full(full[1]),
    .overflow(overflow[1]));

  int checks = 0;
  int errors = 0;

  // Reference model: history as physical array + total stored writes;
  // debounce as the length of the current run of identical valid readings.
  logic [EW-1:0] m_phys [2][D];
  int            m_writes [2];
  logic [EW-1:0] m_stable [2];
  bit            m_new [2];
  bit            m_ovf [2];
  logic [EW-1:0] m_rd [2];
  logic [EW-1:0] m_run_val;
  int            m_run_len;

  function automatic int m_count(input int k);
    return (m_writes[k] < D) ? m_writes[k] : D;
  endfunction

  function automatic logic [EW-1:0] m_read(input int k, input int idx);
    int c, oldest;
    c = m_count(k);
    if (idx >= c) return BL;
    oldest = (c == D) ? (m_writes[k] % D) : 0;
    return m_phys[k][(oldest + idx) % D];
  endfunction

  function automatic logic [D*EW-1:0] m_flat(input int k);
    logic [D*EW-1:0] f;
    for (int i = 0; i < D; i++) f[i*EW +: EW] = m_phys[k][i];
    return f;
  endfunction

  function automatic bit has_blank(input logic [EW-1:0] v);
    for (int i = 0; i < ND; i++) if (v[i*4 +: 4] == 4'hF) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [EW-1:0] plate(input int p);
    return EW'((p / 10) * 16 + (p % 10));
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < D; i++) m_phys[k][i] = BL;
      m_writes[k] = 0;
      m_stable[k] = BL;
      m_new[k]    = 1'b0;
      m_ovf[k]    = 1'b0;
      m_rd[k]     = BL;
    end
    m_run_val = BL;
    m_run_len = 0;
  endfunction

  function automatic void model_step(input bit fe, input logic [EW-1:0] d, input bit clr);
    for (int k = 0; k < 2; k++) m_new[k] = 1'b0;
    if (clr) begin
      model_reset();
    end else if (fe) begin
      if (has_blank(d)) begin
        m_run_len = 0;
      end else if (m_run_len > 0 && d == m_run_val) begin
        m_run_len++;
      end else begin
        m_run_val = d;
        m_run_len = 1;
      end
      if (m_run_len == SF) begin
        for (int k = 0; k < 2; k++) begin
          if (!(m_count(k) > 0 && d == m_stable[k])) begin
            if (m_count(k) == D) m_ovf[k] = 1'b1;
            if (m_count(k) < D || k == 0) begin
              m_phys[k][m_writes[k] % D] = d;
              m_writes[k]++;
              m_stable[k] = d;
              m_new[k]    = 1'b1;
            end
          end
        end
      end
    end
  endfunction

  // Drive one clock cycle from a negedge and advance the model.
  task automatic cycle(input bit fe, input logic [EW-1:0] d, input bit clr, input logic [4:0] ri);
    frame_end = fe;
    digit     = d;
    clear     = clr;
    rd_idx    = ri;
    for (int k = 0; k < 2; k++) m_rd[k] = clr ? BL : m_read(k, int'(ri));
    model_step(fe, d, clr);
    @(negedge clk);
    frame_end = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++; if (count[k] !== 5'd0) begin errors++; $display("FAIL reset_count[%0d] got %0d want 0", k, count[k]); end
      checks++; if (wr_ptr[k] !== 5'd0) begin errors++; $display("FAIL reset_wr_ptr[%0d] got %0d want 0", k, wr_ptr[k]); end
      checks++; if (full[k] !== 1'b0 || overflow[k] !== 1'b0 || new_id[k] !== 1'b0) begin errors++; $display("FAIL reset_flags[%0d] got full=%b ovf=%b new=%b want 0", k, full[k], overflow[k], new_id[k]); end
      checks++; if (stable_id[k] !== BL) begin errors++; $display("FAIL reset_stable[%0d] got %h want %h", k, stable_id[k], BL); end
      checks++; if (rd_data[k] !== BL) begin errors++; $display("FAIL reset_rd_data[%0d] got %h want %h", k, rd_data[k], BL); end
      checks++; if (hist_flat[k] !== {D{BL}}) begin errors++; $display("FAIL reset_hist[%0d] got %h", k, hist_flat[k]); end
    end
    rst_n = 1'b1;
    cycle(1'b0, '0, 1'b0, 5'd0);
  endtask

  task automatic test_basic();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 20'h12345, 1'b0, 5'd0);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (new_id[k] !== (i == 2)) begin errors++; $display("FAIL basic_new_id[%0d] frame %0d got %b want %b", k, i, new_id[k], i == 2); end
      end
    end
    cycle(1'b0, '0, 1'b0, 5'd0);
    for (int k = 0; k < 2; k++) begin
      checks++; if (count[k] !== 5'd1) begin errors++; $display("FAIL basic_count[%0d] got %0d want 1", k, count[k]); end
      checks++; if (stable_id[k] !== 20'h12345) begin errors++; $display("FAIL basic_stable[%0d] got %h want 12345", k, stable_id[k]); end
      checks++; if (rd_data[k] !== 20'h12345) begin errors++; $display("FAIL basic_rd_data[%0d] got %h want 12345", k, rd_data[k]); end
      checks++; if (new_id[k] !== 1'b0) begin errors++; $display("FAIL basic_new_id_drop[%0d] got %b want 0", k, new_id[k]); end
    end
  endtask

  task automatic test_change();
    logic [EW-1:0] seq [5];
    int pulses;
    seq = '{20'h12345, 20'h12345, 20'h54321, 20'h54321, 20'h54321};
    pulses = 0;
    cycle(1'b0, '0, 1'b1, 5'd0);
    foreach (seq[i]) begin
      cycle(1'b1, seq[i], 1'b0, 5'd0);
      if (new_id[0] === 1'b1) pulses++;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL change_pulses got %0d want 1", pulses); end
    checks++; if (stable_id[0] !== 20'h54321) begin errors++; $display("FAIL change_stable got %h want 54321", stable_id[0]); end
    checks++; if (count[0] !== 5'd1) begin errors++; $display("FAIL change_count got %0d want 1", count[0]); end
  endtask

  task automatic test_dedupe();
    logic [EW-1:0] seq [5];
    int pulses;
    seq = '{20'hF1111, 20'hF1111, 20'h11111, 20'h11111, 20'h11111};
    pulses = 0;
    cycle(1'b0, '0, 1'b1, 5'd0);
    repeat (3) cycle(1'b1, 20'h11111, 1'b0, 5'd0);
    checks++; if (new_id[0] !== 1'b1 || count[0] !== 5'd1) begin errors++; $display("FAIL dedupe_first got new=%b count=%0d want 1 1", new_id[0], count[0]); end
    foreach (seq[i]) begin
      cycle(1'b1, seq[i], 1'b0, 5'd0);
      if (new_id[0] === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL dedupe_pulses got %0d want 0", pulses); end
    checks++; if (count[0] !== 5'd1) begin errors++; $display("FAIL dedupe_count got %0d want 1", count[0]); end
  endtask

  task automatic test_fill();
    cycle(1'b0, '0, 1'b1, 5'd0);
    for (int p = 1; p <= 21; p++) begin
      for (int f = 0; f < 3; f++) cycle(1'b1, plate(p), 1'b0, 5'd0);
    end
    checks++; if (new_id[0] !== 1'b1 || new_id[1] !== 1'b0) begin errors++; $display("FAIL fill_last_new got ow=%b drop=%b want 1 0", new_id[0], new_id[1]); end
    for (int k = 0; k < 2; k++) begin
      checks++; if (count[k] !== 5'd20 || full[k] !== 1'b1 || overflow[k] !== 1'b1) begin errors++; $display("FAIL fill_occ[%0d] got count=%0d full=%b ovf=%b want 20 1 1", k, count[k], full[k], overflow[k]); end
      checks++; if (wr_ptr[k] !== ((k == 0) ? 5'd1 : 5'd0)) begin errors++; $display("FAIL fill_wr_ptr[%0d] got %0d want %0d", k, wr_ptr[k], (k == 0) ? 1 : 0); end
      checks++; if (stable_id[k] !== plate(21 - k)) begin errors++; $display("FAIL fill_stable[%0d] got %h want %h", k, stable_id[k], plate(21 - k)); end
      checks++; if (hist_flat[k] !== m_flat(k)) begin errors++; $display("FAIL fill_hist[%0d] got %h want %h", k, hist_flat[k], m_flat(k)); end
    end
    cycle(1'b0, '0, 1'b0, 5'd0);
    checks++; if (rd_data[0] !== plate(2) || rd_data[1] !== plate(1)) begin errors++; $display("FAIL fill_rd_oldest got %h %h want %h %h", rd_data[0], rd_data[1], plate(2), plate(1)); end
    cycle(1'b0, '0, 1'b0, 5'd19);
    checks++; if (rd_data[0] !== plate(21) || rd_data[1] !== plate(20)) begin errors++; $display("FAIL fill_rd_newest got %h %h want %h %h", rd_data[0], rd_data[1], plate(21), plate(20)); end
  endtask

  task automatic test_clear_collision();
    cycle(1'b0, '0, 1'b1, 5'd0);
    repeat (3) cycle(1'b1, 20'h12345, 1'b0, 5'd0);
    repeat (2) cycle(1'b1, 20'h54321, 1'b0, 5'd0);
    cycle(1'b1, 20'h54321, 1'b1, 5'd0);
    for (int k = 0; k < 2; k++) begin
      checks++; if (count[k] !== 5'd0 || wr_ptr[k] !== 5'd0 || new_id[k] !== 1'b0) begin errors++; $display("FAIL clr_state[%0d] got count=%0d wr=%0d new=%b want 0", k, count[k], wr_ptr[k], new_id[k]); end
      checks++; if (stable_id[k] !== BL || rd_data[k] !== BL || hist_flat[k] !== {D{BL}}) begin errors++; $display("FAIL clr_data[%0d] got stable=%h rd=%h", k, stable_id[k], rd_data[k]); end
    end
    repeat (2) cycle(1'b1, 20'h54321, 1'b0, 5'd0);
    checks++; if (new_id[0] !== 1'b0) begin errors++; $display("FAIL clr_streak got new=%b want 0", new_id[0]); end
    cycle(1'b1, 20'h54321, 1'b0, 5'd0);
    checks++; if (new_id[0] !== 1'b1 || count[0] !== 5'd1) begin errors++; $display("FAIL clr_recommit got new=%b count=%0d want 1 1", new_id[0], count[0]); end
  endtask

  task automatic test_async_reset();
    cycle(1'b0, '0, 1'b1, 5'd0);
    repeat (3) cycle(1'b1, 20'h12345, 1'b0, 5'd0);
    cycle(1'b0, '0, 1'b0, 5'd0);
    checks++; if (rd_data[0] !== 20'h12345) begin errors++; $display("FAIL arst_pre_rd got %h want 12345", rd_data[0]); end
    repeat (2) cycle(1'b1, 20'h54321, 1'b0, 5'd0);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++; if (count[k] !== 5'd0 || wr_ptr[k] !== 5'd0) begin errors++; $display("FAIL arst_occ[%0d] got count=%0d wr=%0d want 0", k, count[k], wr_ptr[k]); end
      checks++; if (stable_id[k] !== BL || rd_data[k] !== BL || hist_flat[k] !== {D{BL}}) begin errors++; $display("FAIL arst_data[%0d] got stable=%h rd=%h", k, stable_id[k], rd_data[k]); end
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) cycle(1'b1, 20'h54321, 1'b0, 5'd0);
    checks++; if (new_id[0] !== 1'b0) begin errors++; $display("FAIL arst_streak got new=%b want 0", new_id[0]); end
    cycle(1'b1, 20'h54321, 1'b0, 5'd0);
    checks++; if (new_id[0] !== 1'b1 || count[0] !== 5'd1) begin errors++; $display("FAIL arst_commit got new=%b count=%0d want 1 1", new_id[0], count[0]); end
  endtask

  task automatic test_random();
    logic [EW-1:0] pool [5];
    logic [EW-1:0] d;
    int pick;
    pool = '{20'h12345, 20'h54321, 20'h0A0B0, 20'h99999, 20'h12F45};
    pick = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) < 4) pick = int'($urandom_range(0, 5));
      d = (pick == 5) ? EW'($urandom) : pool[pick];
      cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 799) == 0, 5'($urandom_range(0, 31)));
      for (int k = 0; k < 2; k++) begin
        checks++; if (count[k] !== 5'(m_count(k)) || full[k] !== (m_count(k) == D)) begin errors++; $display("FAIL rnd_occ[%0d] n=%0d got count=%0d full=%b want %0d", k, n, count[k], full[k], m_count(k)); end
        checks++; if (wr_ptr[k] !== 5'(m_writes[k] % D)) begin errors++; $display("FAIL rnd_wr_ptr[%0d] n=%0d got %0d want %0d", k, n, wr_ptr[k], m_writes[k] % D); end
        checks++; if (new_id[k] !== m_new[k] || overflow[k] !== m_ovf[k]) begin errors++; $display("FAIL rnd_flags[%0d] n=%0d got new=%b ovf=%b want %b %b", k, n, new_id[k], overflow[k], m_new[k], m_ovf[k]); end
        checks++; if (stable_id[k] !== m_stable[k]) begin errors++; $display("FAIL rnd_stable[%0d] n=%0d got %h want %h", k, n, stable_id[k], m_stable[k]); end
        checks++; if (rd_data[k] !== m_rd[k]) begin errors++; $display("FAIL rnd_rd_data[%0d] n=%0d got %h want %h", k, n, rd_data[k], m_rd[k]); end
        checks++; if (hist_flat[k] !== m_flat(k)) begin errors++; $display("FAIL rnd_hist[%0d] n=%0d got %h want %h", k, n, hist_flat[k], m_flat(k)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_change();
    test_dedupe();
    test_fill();
    test_clear_collision();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/plate_id_history.md
# plate_id_history

Parametrised successor to the plate-result saver: takes the per-frame plate digits produced by the image-handling stage, debounces them over several consecutive frames, and commits each stable, new plate into a circular history buffer. It sits between the recognition output (next to the 7-segment driver) and downstream readout logic. Unlike the existing saver, it generalises digit count, digit width, stability depth and history depth, and adds a readout port, overflow policy and commit pulse.

## Interface
- NUM_DIGITS, 5, digits per plate
- DIGIT_W, 4, bits per digit
- BLANK, 4'hF, per-digit "not recognised" code (DIGIT_W wide)
- STABLE_FRAMES, 3, identical consecutive readings needed to commit (≥1)
- HIST_DEPTH, 20, history entries (≥2); ENTRY_W = NUM_DIGITS*DIGIT_W
- OVERWRITE, 1, 1 = overwrite oldest when full, 0 = drop new
- clk  in  1  single clock; all ports synchronous to it
- rst_n  in  1  asynchronous, active-low reset
- frame_end  in  1  one-cycle strobe; sample `digit` this cycle
- digit  in  ENTRY_W  current reading, digit 0 in LSBs
- clear  in  1  synchronous clear of all state and history
- rd_idx  in  $clog2(HIST_DEPTH)  logical index, 0 = oldest entry
- rd_data  out  ENTRY_W  entry at rd_idx, registered
- hist_flat  out  HIST_DEPTH*ENTRY_W  physical slot i at [i*ENTRY_W +: ENTRY_W]
- wr_ptr  out  $clog2(HIST_DEPTH)  next physical slot to write
- count  out  $clog2(HIST_DEPTH+1)  valid entries
- stable_id  out  ENTRY_W  most recently committed plate
- new_id  out  1  one-cycle pulse on commit
- full  out  1  count == HIST_DEPTH
- overflow  out  1  sticky: a commit arrived while full

## Operation
- Reading is invalid if any digit equals BLANK.
- FSM on frame_end only: IDLE, TRACK (candidate + streak counter), LOCKED.
- Invalid reading, any state → IDLE, streak 0.
- IDLE + valid → TRACK, cand = digit, streak = 1.
- TRACK + valid == cand → streak+1; TRACK + valid ≠ cand → cand = digit, streak = 1.
- Whenever streak reaches STABLE_FRAMES → LOCKED and commit attempt (STABLE_FRAMES = 1 commits on the first valid reading).
- LOCKED + same → stay, no commit; LOCKED + different valid → TRACK, streak = 1.
- Commit attempt: skipped (no pulse) if count > 0 and cand == stable_id (dedupe against last commit, even across blank gaps).
- Not full: write slot wr_ptr, wr_ptr wraps HIST_DEPTH-1 → 0, count+1.
- Full, OVERWRITE = 1: write slot wr_ptr (the oldest), oldest pointer advances with it, count stays, overflow set, new_id pulses.
- Full, OVERWRITE = 0: no write, overflow set, no new_id, stable_id unchanged.
- On every performed write: stable_id = cand, new_id = 1.
- Read: rd_data = slot[(oldest + rd_idx) mod HIST_DEPTH]; rd_idx ≥ count → all-BLANK.
- clear: same effect as reset; clear beats simultaneous frame_end.

## Timing
- Reset/clear values: all slots, stable_id, rd_data = all-BLANK; count, wr_ptr, oldest, streak, new_id, full, overflow = 0; FSM IDLE.
- frame_end sampled at edge N; state, slot, count, full, stable_id, hist_flat, new_id visible after edge N (cycle N+1); new_id drops after N+1.
- rd_data: 1-cycle latency from rd_idx; reflects a write from the same edge one cycle later.
- Back-to-back frame_end strobes each processed; no stall, no handshake.
- Reset asserted mid-stream clears immediately, independent of clk.

## Structure
- Package plate_pkg: DIGIT_W, NUM_DIGITS, BLANK, ENTRY_W, state enum {IDLE, TRACK, LOCKED}, is_blank function.
- Sub-module plate_hist_ram: circular storage, wr_ptr/oldest/count, registered logical read port, full/overflow. Top holds FSM, candidate, streak, dedupe.

## Test plan
- Reset; 3 frames of 0x12345 → one new_id after third, count 1, stable_id 0x12345, rd_idx 0 → 0x12345 next cycle.
- 0x12345, 0x12345, 0x54321, 0x54321, 0x54321 → single commit of 0x54321, no commit of 0x12345.
- Commit 0x11111, 2 blank frames (0xF1111), 3×0x11111 → no second commit, count stays 1.
- 21 distinct plates, OVERWRITE = 1 → count 20, full, overflow, rd_idx 0 = plate 2, rd_idx 19 = plate 21, wr_ptr 1.
- Same with OVERWRITE = 0 → 21st drops, no new_id, rd_idx 19 = plate 20, overflow = 1.
- clear and frame_end in same cycle at streak 2 → all reset values, no commit; async rst_n mid-TRACK → outputs at reset values before next edge.
